// File: rtl/paritet_kodek_stream.sv
// Streaming parity encoder and checker: two independent single-register valid/ready stages.
// Define PARITET_BROJAC_GRESAKA_EN to build the saturating parity-error counter on br_gresaka.
module paritet_kodek_stream #(
    parameter int SIRINA  = 40,
    parameter int NEPARNA = 0
) (
    input  logic              clk,
    input  logic              rst,
    // encoder side
    input  logic              ulaz_valid,
    output logic              ulaz_ready,
    input  logic [SIRINA-1:0] ulaz_podatak,
    output logic              kod_valid,
    input  logic              kod_ready,
    output logic [SIRINA:0]   izlaz_kod,
    // decoder side
    input  logic              dek_valid,
    output logic              dek_ready,
    input  logic [SIRINA:0]   dek_kod,
    output logic              izlaz_valid,
    input  logic              izlaz_ready,
    output logic [SIRINA-1:0] izlaz_podatak,
    output logic              greska,
    output logic [15:0]       br_gresaka
);

    localparam logic PARITET_INIT = (NEPARNA != 0);

    logic              kod_valid_q, kod_valid_d;
    logic [SIRINA:0]   kod_q, kod_d;
    logic              enc_prijem;

    logic              izl_valid_q, izl_valid_d;
    logic [SIRINA-1:0] podatak_q, podatak_d;
    logic              greska_q, greska_d;
    logic              dek_prijem;
    logic              dek_greska;

    // Ready is forced low during reset so nothing is accepted into a stage being cleared.
    assign ulaz_ready = !rst && (!kod_valid_q || kod_ready);
    assign enc_prijem = ulaz_valid && ulaz_ready;

    always_comb begin
        kod_valid_d = kod_valid_q;
        kod_d       = kod_q;
        if (enc_prijem) begin
            kod_d       = {ulaz_podatak, (^ulaz_podatak) ^ PARITET_INIT};
            kod_valid_d = 1'b1;
        end else if (kod_ready) begin
            kod_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            kod_valid_q <= 1'b0;
            kod_q       <= '0;
        end else begin
            kod_valid_q <= kod_valid_d;
            kod_q       <= kod_d;
        end
    end

    assign kod_valid = kod_valid_q;
    assign izlaz_kod = kod_q;

    assign dek_ready  = !rst && (!izl_valid_q || izlaz_ready);
    assign dek_prijem = dek_valid && dek_ready;
    assign dek_greska = (^dek_kod) ^ PARITET_INIT;

    always_comb begin
        izl_valid_d = izl_valid_q;
        podatak_d   = podatak_q;
        greska_d    = greska_q;
        if (dek_prijem) begin
            podatak_d   = dek_kod[SIRINA:1];
            greska_d    = dek_greska;
            izl_valid_d = 1'b1;
        end else if (izlaz_ready) begin
            izl_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            izl_valid_q <= 1'b0;
            podatak_q   <= '0;
            greska_q    <= 1'b0;
        end else begin
            izl_valid_q <= izl_valid_d;
            podatak_q   <= podatak_d;
            greska_q    <= greska_d;
        end
    end

    assign izlaz_valid   = izl_valid_q;
    assign izlaz_podatak = podatak_q;
    assign greska        = greska_q;

`ifdef PARITET_BROJAC_GRESAKA_EN
    logic [15:0] brojac_q, brojac_d;

    always_comb begin
        brojac_d = brojac_q;
        if (dek_prijem && dek_greska && (brojac_q != 16'hFFFF)) begin
            brojac_d = brojac_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            brojac_q <= '0;
        end else begin
            brojac_q <= brojac_d;
        end
    end

    assign br_gresaka = brojac_q;
`else
    assign br_gresaka = 16'h0000;
`endif

endmodule

// File: tb/tb_paritet_kodek_stream.sv
// Scoreboard bench for paritet_kodek_stream: directed vectors, backpressure, streaming, random traffic, reset.
module tb_paritet_kodek_stream;

    localparam int W = 40;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          ulaz_valid, ulaz_ready, kod_valid, kod_ready;
    logic [W-1:0]  ulaz_podatak;
    logic [W:0]    izlaz_kod;
    logic          dek_valid, dek_ready, izlaz_valid, izlaz_ready, greska;
    logic [W:0]    dek_kod;
    logic [W-1:0]  izlaz_podatak;
    logic [15:0]   br_gresaka;

    paritet_kodek_stream #(.SIRINA(W), .NEPARNA(0)) dut (
        .clk(clk), .rst(rst),
        .ulaz_valid(ulaz_valid), .ulaz_ready(ulaz_ready), .ulaz_podatak(ulaz_podatak),
        .kod_valid(kod_valid), .kod_ready(kod_ready), .izlaz_kod(izlaz_kod),
        .dek_valid(dek_valid), .dek_ready(dek_ready), .dek_kod(dek_kod),
        .izlaz_valid(izlaz_valid), .izlaz_ready(izlaz_ready), .izlaz_podatak(izlaz_podatak),
        .greska(greska), .br_gresaka(br_gresaka)
    );

    // Two narrow instances (even and odd parity) share one stimulus.
    logic         s_ulaz_valid, s_kod_ready, s_dek_valid, s_izlaz_ready;
    logic [11:0]  s_ulaz_podatak;
    logic [12:0]  s_dek_kod;
    logic         s0_ulaz_ready, s0_kod_valid, s0_dek_ready, s0_izlaz_valid, s0_greska;
    logic         s1_ulaz_ready, s1_kod_valid, s1_dek_ready, s1_izlaz_valid, s1_greska;
    logic [12:0]  s0_kod, s1_kod;
    logic [11:0]  s0_podatak, s1_podatak;
    logic [15:0]  s0_br, s1_br;

    paritet_kodek_stream #(.SIRINA(12), .NEPARNA(0)) dut_s0 (
        .clk(clk), .rst(rst),
        .ulaz_valid(s_ulaz_valid), .ulaz_ready(s0_ulaz_ready), .ulaz_podatak(s_ulaz_podatak),
        .kod_valid(s0_kod_valid), .kod_ready(s_kod_ready), .izlaz_kod(s0_kod),
        .dek_valid(s_dek_valid), .dek_ready(s0_dek_ready), .dek_kod(s_dek_kod),
        .izlaz_valid(s0_izlaz_valid), .izlaz_ready(s_izlaz_ready), .izlaz_podatak(s0_podatak),
        .greska(s0_greska), .br_gresaka(s0_br)
    );

    paritet_kodek_stream #(.SIRINA(12), .NEPARNA(1)) dut_s1 (
        .clk(clk), .rst(rst),
        .ulaz_valid(s_ulaz_valid), .ulaz_ready(s1_ulaz_ready), .ulaz_podatak(s_ulaz_podatak),
        .kod_valid(s1_kod_valid), .kod_ready(s_kod_ready), .izlaz_kod(s1_kod),
        .dek_valid(s_dek_valid), .dek_ready(s1_dek_ready), .dek_kod(s_dek_kod),
        .izlaz_valid(s1_izlaz_valid), .izlaz_ready(s_izlaz_ready), .izlaz_podatak(s1_podatak),
        .greska(s1_greska), .br_gresaka(s1_br)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

`ifdef PARITET_BROJAC_GRESAKA_EN
    localparam bit BROJAC_EN = 1'b1;
`else
    localparam bit BROJAC_EN = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] podatak;
        logic         greska;
        logic [15:0]  br;
    } dek_stavka_t;

    logic [W:0]  enc_sb[$];
    dek_stavka_t dek_sb[$];
    logic [15:0] err_model = '0;

    int cyc         = 0;
    bit stream_on   = 1'b0;
    int stream_pops = 0;
    int stream_gaps = 0;
    int last_pop    = 0;

    // Monitor: inputs are driven 1 time unit after posedge, so the negedge sees what the next edge transfers.
    always @(negedge clk) begin
        logic [W:0]  e;
        dek_stavka_t d;
        cyc++;
        if (rst) begin
            enc_sb.delete();
            dek_sb.delete();
            err_model = '0;
        end else begin
            if (kod_valid && kod_ready) begin
                if (enc_sb.size() == 0) begin
                    check("enc_unexpected_word", 64'd1, 64'd0);
                end else begin
                    e = enc_sb.pop_front();
                    check("enc_kod", 64'(izlaz_kod), 64'(e));
                end
                if (stream_on) begin
                    if (stream_pops > 0 && cyc != last_pop + 1) stream_gaps++;
                    stream_pops++;
                    last_pop = cyc;
                end
            end
            if (ulaz_valid && ulaz_ready)
                enc_sb.push_back({ulaz_podatak, ^ulaz_podatak});

            if (izlaz_valid && izlaz_ready) begin
                if (dek_sb.size() == 0) begin
                    check("dek_unexpected_word", 64'd1, 64'd0);
                end else begin
                    d = dek_sb.pop_front();
                    check("dek_podatak", 64'(izlaz_podatak), 64'(d.podatak));
                    check("dek_greska", 64'(greska), 64'(d.greska));
                    check("dek_br_gresaka", 64'(br_gresaka), 64'(d.br));
                end
            end
            if (dek_valid && dek_ready) begin
                d.podatak = dek_kod[W:1];
                d.greska  = ^dek_kod;
                if (d.greska && err_model != 16'hFFFF) err_model = err_model + 16'd1;
                d.br      = BROJAC_EN ? err_model : 16'h0000;
                dek_sb.push_back(d);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W:0] napravi_kod(input logic [W-1:0] p, input bit pokvari);
        logic [W:0] k;
        k = {p, ^p};
        if (pokvari) k[$urandom_range(W, 0)] ^= 1'b1;
        return k;
    endfunction

    logic [W:0] prvi_kod;

    initial begin
        rst = 1'b1;
        ulaz_valid = 0; kod_ready = 1; ulaz_podatak = '0;
        dek_valid = 0; izlaz_ready = 1; dek_kod = '0;
        s_ulaz_valid = 0; s_kod_ready = 1; s_ulaz_podatak = '0;
        s_dek_valid = 0; s_izlaz_ready = 1; s_dek_kod = '0;
        step(); step();

        check("rst_kod_valid", 64'(kod_valid), 64'd0);
        check("rst_izlaz_valid", 64'(izlaz_valid), 64'd0);
        check("rst_izlaz_kod", 64'(izlaz_kod), 64'd0);
        check("rst_ulaz_ready", 64'(ulaz_ready), 64'd0);
        check("rst_dek_ready", 64'(dek_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ulaz_ready", 64'(ulaz_ready), 64'd1);
        check("post_rst_dek_ready", 64'(dek_ready), 64'd1);
        step();

        // Directed encoder vector, 40-bit even parity
        ulaz_podatak = 40'h646a6f6c65; ulaz_valid = 1;
        step();
        ulaz_valid = 0;
        check("dir_izlaz_kod", 64'(izlaz_kod), 64'h0C8D4DED8CB);
        check("dir_kod_valid", 64'(kod_valid), 64'd1);

        // Directed 12-bit vectors, even and odd parity
        s_ulaz_podatak = 12'b011001001000; s_ulaz_valid = 1;
        step();
        s_ulaz_valid = 0;
        check("s0_izlaz_kod", 64'(s0_kod), 64'h0C90);
        check("s1_izlaz_kod", 64'(s1_kod), 64'h0C91);
        check("s0_kod_valid", 64'(s0_kod_valid), 64'd1);
        step();

        // Directed decoder vectors: clean then corrupted codeword
        dek_kod = 41'h0C8D4DED8CB; dek_valid = 1;
        step();
        check("dir_dek_podatak", 64'(izlaz_podatak), 64'h646a6f6c65);
        check("dir_dek_greska0", 64'(greska), 64'd0);
        dek_kod = 41'h0C8D4DED8CA;
        step();
        dek_valid = 0;
        check("dir_dek_greska1", 64'(greska), 64'd1);
        check("dir_br_gresaka", 64'(br_gresaka), BROJAC_EN ? 64'd1 : 64'd0);
        step();

        // Backpressure: first word must hold while kod_ready is low
        kod_ready = 0;
        ulaz_podatak = 40'h12_3456_789A; ulaz_valid = 1;
        prvi_kod = {40'h12_3456_789A, ^(40'h12_3456_789A)};
        step();
        ulaz_podatak = 40'hA5_5AA5_5A0F;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_kod", 64'(izlaz_kod), 64'(prvi_kod));
            check("bp_hold_valid", 64'(kod_valid), 64'd1);
            check("bp_ulaz_ready", 64'(ulaz_ready), 64'd0);
        end
        kod_ready = 1;
        step();
        ulaz_valid = 0;
        step(); step();
        check("bp_sb_empty", 64'(enc_sb.size()), 64'd0);

        // Streaming: 100 back-to-back words must exit on 100 consecutive cycles
        stream_on = 1;
        ulaz_valid = 1;
        for (int i = 0; i < 100; i++) begin
            ulaz_podatak = {$urandom, $urandom};
            step();
        end
        ulaz_valid = 0;
        for (int i = 0; i < 10 && enc_sb.size() != 0; i++) step();
        step();
        stream_on = 0;
        check("stream_pops", 64'(stream_pops), 64'd100);
        check("stream_gaps", 64'(stream_gaps), 64'd0);

        // Random concurrent traffic on both paths with injected parity errors
        for (int i = 0; i < 400; i++) begin
            ulaz_valid   = ($urandom_range(3, 0) != 0);
            ulaz_podatak = {$urandom, $urandom};
            kod_ready    = ($urandom_range(3, 0) != 0);
            dek_valid    = ($urandom_range(3, 0) != 0);
            dek_kod      = napravi_kod({$urandom, $urandom}, $urandom_range(2, 0) == 0);
            izlaz_ready  = ($urandom_range(3, 0) != 0);
            step();
        end
        ulaz_valid = 0; dek_valid = 0; kod_ready = 1; izlaz_ready = 1;
        for (int i = 0; i < 20 && (enc_sb.size() != 0 || dek_sb.size() != 0); i++) step();
        check("drain_enc_sb", 64'(enc_sb.size()), 64'd0);
        check("drain_dek_sb", 64'(dek_sb.size()), 64'd0);

        // Reset with both stages full and stalled
        kod_ready = 0; izlaz_ready = 0;
        ulaz_valid = 1; ulaz_podatak = 40'hFF_0000_FFFF;
        dek_valid = 1; dek_kod = 41'h0C8D4DED8CA;
        step();
        ulaz_valid = 0; dek_valid = 0;
        check("pre_rst_kod_valid", 64'(kod_valid), 64'd1);
        check("pre_rst_izlaz_valid", 64'(izlaz_valid), 64'd1);
        rst = 1;
        step();
        check("mid_rst_kod_valid", 64'(kod_valid), 64'd0);
        check("mid_rst_izlaz_valid", 64'(izlaz_valid), 64'd0);
        check("mid_rst_izlaz_kod", 64'(izlaz_kod), 64'd0);
        check("mid_rst_izlaz_podatak", 64'(izlaz_podatak), 64'd0);
        check("mid_rst_greska", 64'(greska), 64'd0);
        check("mid_rst_br_gresaka", 64'(br_gresaka), 64'd0);
        check("mid_rst_ulaz_ready", 64'(ulaz_ready), 64'd0);
        check("mid_rst_dek_ready", 64'(dek_ready), 64'd0);
        rst = 0;
        step();
        check("after_rst_ulaz_ready", 64'(ulaz_ready), 64'd1);
        check("after_rst_dek_ready", 64'(dek_ready), 64'd1);
        check("after_rst_kod_valid", 64'(kod_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
